// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the two-master SPI bus arbiter.
package spi_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_OWN0  = 2'd1,
    ARB_OWN1  = 2'd2,
    ARB_GUARD = 2'd3
  } arb_state_t;

  typedef logic arb_owner_t;

  localparam int unsigned ARB_GUARD_W = 4;

  // True while one of the masters owns the pads.
  function automatic logic arb_is_own(input arb_state_t s);
    return (s == ARB_OWN0) || (s == ARB_OWN1);
  endfunction

endpackage

// File: rtl/spi_arb_cnt.sv
// Loadable down-counter with zero flag. Holds at zero once reached;
// load has priority over decrement.
module spi_arb_cnt #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  // Counter register: load, else saturating decrement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  // Zero flag decode.
  always_comb begin
    zero = (cnt == '0);
  end

endmodule

// File: rtl/spi_bus_arbiter.sv
// Round-robin arbiter sharing one SPI pad set between two SPI masters,
// with a chip-select-high guard gap between owners.
// Optional feature macro: SPI_ARB_TIMEOUT_EN (grant length limit with
// forced revoke and one-cycle timeout pulse).
module spi_bus_arbiter
  import spi_arb_pkg::*;
#(
  parameter int unsigned GUARD_CYCLES   = 2,
  parameter logic        IDLE_SCLK      = 1'b0,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic clk,
  input  logic rst_n,
  input  logic m0_req,
  output logic m0_gnt,
  input  logic m0_sclk,
  input  logic m0_mosi,
  input  logic m0_cs_n,
  output logic m0_miso,
  input  logic m1_req,
  output logic m1_gnt,
  input  logic m1_sclk,
  input  logic m1_mosi,
  input  logic m1_cs_n,
  output logic m1_miso,
  input  logic spi_miso,
  output logic spi_clk,
  output logic spi_mosi,
  output logic spi_cs1_n,
  output logic spi_cs2_n,
  output logic timeout
);

  if ((GUARD_CYCLES < 1) || (GUARD_CYCLES > 15)) begin : g_bad_guard
    $error("spi_bus_arbiter: GUARD_CYCLES must be in 1..15");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("spi_bus_arbiter: TIMEOUT_CYCLES must be at least 2");
  end

  arb_state_t state_q, state_d;
  arb_owner_t last_owner;
  logic       guard_load;
  logic       guard_dec;
  logic       guard_zero;
  logic       req0_eff;
  logic       req1_eff;
  logic       to_hit;

  spi_arb_cnt #(
    .W(ARB_GUARD_W)
  ) u_guard_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (guard_load),
    .load_val (ARB_GUARD_W'(GUARD_CYCLES - 1)),
    .dec      (guard_dec),
    .zero     (guard_zero)
  );

  // Guard timer control: load on any entry to GUARD, count down while in it.
  always_comb begin
    guard_load = arb_is_own(state_q) && (state_d == ARB_GUARD);
    guard_dec  = (state_q == ARB_GUARD);
  end

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES);

  logic to_load;
  logic to_dec;
  logic to_zero;
  logic mask0;
  logic mask1;

  // Down-counter loaded with TIMEOUT_CYCLES-1 on grant: reaching zero in the
  // last owned cycle is equivalent to an up-counter hitting TIMEOUT_CYCLES.
  spi_arb_cnt #(
    .W(TO_W)
  ) u_to_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (to_load),
    .load_val (TO_W'(TIMEOUT_CYCLES - 1)),
    .dec      (to_dec),
    .zero     (to_zero)
  );

  // Timeout timer control and expiry decode.
  always_comb begin
    to_load  = (state_q == ARB_IDLE) && arb_is_own(state_d);
    to_dec   = arb_is_own(state_q);
    to_hit   = arb_is_own(state_q) && to_zero;
    req0_eff = m0_req && !mask0;
    req1_eff = m1_req && !mask1;
  end

  // Revoked master stays masked until its request is seen low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask0 <= 1'b0;
      mask1 <= 1'b0;
    end else begin
      if (!m0_req) begin
        mask0 <= 1'b0;
      end else if ((state_q == ARB_OWN0) && to_hit) begin
        mask0 <= 1'b1;
      end
      if (!m1_req) begin
        mask1 <= 1'b0;
      end else if ((state_q == ARB_OWN1) && to_hit) begin
        mask1 <= 1'b1;
      end
    end
  end

  // One-cycle pulse aligned with the forced drop of gnt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout <= 1'b0;
    end else begin
      timeout <= to_hit && (((state_q == ARB_OWN0) && m0_req) ||
                            ((state_q == ARB_OWN1) && m1_req));
    end
  end
`else
  // No grant limit: requests pass straight through, timeout never fires.
  always_comb begin
    to_hit   = 1'b0;
    req0_eff = m0_req;
    req1_eff = m1_req;
    timeout  = 1'b0;
  end
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: round-robin pick in IDLE, release/revoke in OWNn.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE: begin
        if (req0_eff && req1_eff) begin
          state_d = (last_owner == 1'b0) ? ARB_OWN1 : ARB_OWN0;
        end else if (req0_eff) begin
          state_d = ARB_OWN0;
        end else if (req1_eff) begin
          state_d = ARB_OWN1;
        end
      end
      ARB_OWN0: begin
        if (!m0_req || to_hit) state_d = ARB_GUARD;
      end
      ARB_OWN1: begin
        if (!m1_req || to_hit) state_d = ARB_GUARD;
      end
      ARB_GUARD: begin
        if (guard_zero) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Round-robin pointer and registered grant decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_owner <= 1'b1;
      m0_gnt     <= 1'b0;
      m1_gnt     <= 1'b0;
    end else begin
      if ((state_q == ARB_OWN0) && (state_d == ARB_GUARD)) begin
        last_owner <= 1'b0;
      end else if ((state_q == ARB_OWN1) && (state_d == ARB_GUARD)) begin
        last_owner <= 1'b1;
      end
      m0_gnt <= (state_d == ARB_OWN0);
      m1_gnt <= (state_d == ARB_OWN1);
    end
  end

  // Pad mux: combinational from the registered state, so the owner's SPI
  // timing reaches the pads with no added latency.
  always_comb begin
    spi_clk   = IDLE_SCLK;
    spi_mosi  = 1'b0;
    spi_cs1_n = 1'b1;
    spi_cs2_n = 1'b1;
    m0_miso   = 1'b0;
    m1_miso   = 1'b0;
    case (state_q)
      ARB_OWN0: begin
        spi_clk   = m0_sclk;
        spi_mosi  = m0_mosi;
        spi_cs1_n = m0_cs_n;
        m0_miso   = spi_miso;
      end
      ARB_OWN1: begin
        spi_clk   = m1_sclk;
        spi_mosi  = m1_mosi;
        spi_cs2_n = m1_cs_n;
        m1_miso   = spi_miso;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Directed self-checking bench for spi_bus_arbiter (GUARD_CYCLES=2,
// IDLE_SCLK=0, TIMEOUT_CYCLES=16).
module tb_spi_bus_arbiter;

  logic clk;
  logic rst_n;
  logic m0_req, m0_gnt, m0_sclk, m0_mosi, m0_cs_n, m0_miso;
  logic m1_req, m1_gnt, m1_sclk, m1_mosi, m1_cs_n, m1_miso;
  logic spi_miso, spi_clk, spi_mosi, spi_cs1_n, spi_cs2_n, timeout;

  int n_vec;
  int n_err;

  spi_bus_arbiter #(
    .GUARD_CYCLES   (2),
    .IDLE_SCLK      (1'b0),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .m0_req    (m0_req),
    .m0_gnt    (m0_gnt),
    .m0_sclk   (m0_sclk),
    .m0_mosi   (m0_mosi),
    .m0_cs_n   (m0_cs_n),
    .m0_miso   (m0_miso),
    .m1_req    (m1_req),
    .m1_gnt    (m1_gnt),
    .m1_sclk   (m1_sclk),
    .m1_mosi   (m1_mosi),
    .m1_cs_n   (m1_cs_n),
    .m1_miso   (m1_miso),
    .spi_miso  (spi_miso),
    .spi_clk   (spi_clk),
    .spi_mosi  (spi_mosi),
    .spi_cs1_n (spi_cs1_n),
    .spi_cs2_n (spi_cs2_n),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_pads(input string tag, input logic cs1, input logic cs2,
                            input logic sclk, input logic mosi);
    check({tag, ".cs1_n"}, 32'(spi_cs1_n), 32'(cs1));
    check({tag, ".cs2_n"}, 32'(spi_cs2_n), 32'(cs2));
    check({tag, ".sclk"},  32'(spi_clk),   32'(sclk));
    check({tag, ".mosi"},  32'(spi_mosi),  32'(mosi));
  endtask

  // Advance to just after the next active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count edges until the chosen grant rises, bounded by limit.
  task automatic wait_gnt(input int which, input int limit, output int cycles);
    cycles = 0;
    while (((which == 0) ? m0_gnt : m1_gnt) !== 1'b1 && cycles < limit) begin
      tick();
      cycles++;
    end
  endtask

  task automatic idle_inputs();
    m0_req = 1'b0; m0_sclk = 1'b0; m0_mosi = 1'b0; m0_cs_n = 1'b1;
    m1_req = 1'b0; m1_sclk = 1'b0; m1_mosi = 1'b0; m1_cs_n = 1'b1;
    spi_miso = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    idle_inputs();
    tick();
    tick();
    check("rst.m0_gnt", 32'(m0_gnt), 32'd0);
    check("rst.m1_gnt", 32'(m1_gnt), 32'd0);
    check("rst.timeout", 32'(timeout), 32'd0);
    check_pads("rst", 1'b1, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    int cyc;
    logic exp_s;
    logic cur;
    n_vec = 0;
    n_err = 0;

    apply_reset();

    // 1. Single m0 transaction.
    m0_req = 1'b1;
    #1;
    check("t1.gnt_before_edge", 32'(m0_gnt), 32'd0);
    tick();
    check("t1.gnt_after_edge", 32'(m0_gnt), 32'd1);
    m0_cs_n = 1'b0;
    #1;
    check_pads("t1.cs_low", 1'b0, 1'b1, 1'b0, 1'b0);
    exp_s = 1'b0;
    for (int i = 0; i < 32; i++) begin
      m0_sclk = ~m0_sclk;
      m0_mosi = (i % 3 == 0);
      exp_s = ~exp_s;
      #1;
      check_pads("t1.toggle", 1'b0, 1'b1, exp_s, (i % 3 == 0));
    end
    m0_cs_n = 1'b1;
    m0_mosi = 1'b0;
    #1;
    check("t1.cs1_follows_high", 32'(spi_cs1_n), 32'd1);
    m0_req = 1'b0;
    tick();
    check("t1.gnt_drop", 32'(m0_gnt), 32'd0);
    tick();
    tick();

    // 2. Both request out of reset: m0 first, then m1 after the guard gap.
    apply_reset();
    m0_req = 1'b1;
    m1_req = 1'b1;
    m1_cs_n = 1'b0;
    #1;
    check("t2.early_cs2", 32'(spi_cs2_n), 32'd1);
    tick();
    check("t2.m0_first", 32'(m0_gnt), 32'd1);
    check("t2.m1_wait", 32'(m1_gnt), 32'd0);
    m0_cs_n = 1'b0;
    #1;
    check("t2.cs1_low", 32'(spi_cs1_n), 32'd0);
    m0_req = 1'b0;
    tick();
    check("t2.release.m0_gnt", 32'(m0_gnt), 32'd0);
    check_pads("t2.guard1", 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    check_pads("t2.guard2", 1'b1, 1'b1, 1'b0, 1'b0);
    check("t2.guard2.m1_gnt", 32'(m1_gnt), 32'd0);
    tick();
    check("t2.idle.m1_gnt", 32'(m1_gnt), 32'd0);
    check("t2.idle.cs2", 32'(spi_cs2_n), 32'd1);
    tick();
    check("t2.m1_gnt", 32'(m1_gnt), 32'd1);
    check("t2.cs2_passes", 32'(spi_cs2_n), 32'd0);
    m0_cs_n = 1'b1;
    m1_cs_n = 1'b1;

    // 3. Alternation over 4 rounds; m1 owns, m0 re-requests.
    m0_req = 1'b1;
    #1;
    check("t3.m0_blocked", 32'(m0_gnt), 32'd0);
    for (int r = 0; r < 4; r++) begin
      cur = (r % 2 == 0) ? 1'b1 : 1'b0;
      if (cur) m1_req = 1'b0; else m0_req = 1'b0;
      // Count includes the release edge: release + GUARD_CYCLES + 1.
      wait_gnt(cur ? 0 : 1, 10, cyc);
      check($sformatf("t3.r%0d.latency", r), 32'(cyc), 32'd4);
      check($sformatf("t3.r%0d.prev_gnt", r), 32'(cur ? m1_gnt : m0_gnt), 32'd0);
      if (cur) m1_req = 1'b1; else m0_req = 1'b1;
    end
    check("t3.end.m1_gnt", 32'(m1_gnt), 32'd1);

    // 4. Isolation: m0 owns, ungranted m1 drives cs/sclk.
    m1_req = 1'b0;
    wait_gnt(0, 10, cyc);
    check("t4.m0_latency", 32'(cyc), 32'd4);
    m1_cs_n = 1'b0;
    m1_mosi = 1'b1;
    spi_miso = 1'b1;
    for (int i = 0; i < 4; i++) begin
      m1_sclk = ~m1_sclk;
      #1;
      check_pads("t4.iso", 1'b1, 1'b1, 1'b0, 1'b0);
      check("t4.m1_miso", 32'(m1_miso), 32'd0);
      check("t4.m0_miso", 32'(m0_miso), 32'd1);
    end
    m0_sclk = 1'b1;
    spi_miso = 1'b0;
    #1;
    check("t4.owner_sclk", 32'(spi_clk), 32'd1);
    check("t4.m0_miso_low", 32'(m0_miso), 32'd0);
    m1_cs_n = 1'b1;
    m1_mosi = 1'b0;
    m1_sclk = 1'b0;

    // 5. Reset mid-transfer with m0 owning and cs low.
    m0_cs_n = 1'b0;
    #1;
    check("t5.cs1_low", 32'(spi_cs1_n), 32'd0);
    rst_n = 1'b0;
    #1;
    check("t5.async.cs1", 32'(spi_cs1_n), 32'd1);
    check("t5.async.gnt", 32'(m0_gnt), 32'd0);
    check("t5.async.sclk", 32'(spi_clk), 32'd0);
    tick();
    tick();
    m0_cs_n = 1'b1;
    m0_sclk = 1'b0;
    rst_n = 1'b1;
    #1;
    check("t5.post_rst.gnt", 32'(m0_gnt), 32'd0);
    tick();
    check("t5.regrant", 32'(m0_gnt), 32'd1);

    // 6. Grant length limit.
    apply_reset();
    m0_req = 1'b1;
    m1_req = 1'b1;
    tick();
    check("t6.m0_gnt", 32'(m0_gnt), 32'd1);
`ifdef SPI_ARB_TIMEOUT_EN
    for (int k = 1; k < 16; k++) begin
      tick();
      check($sformatf("t6.hold%0d.gnt", k), 32'(m0_gnt), 32'd1);
      check($sformatf("t6.hold%0d.to", k), 32'(timeout), 32'd0);
    end
    tick();
    check("t6.revoke.gnt", 32'(m0_gnt), 32'd0);
    check("t6.revoke.pulse", 32'(timeout), 32'd1);
    tick();
    check("t6.pulse_end", 32'(timeout), 32'd0);
    tick();
    check("t6.guard.m1_gnt", 32'(m1_gnt), 32'd0);
    tick();
    check("t6.m1_gnt", 32'(m1_gnt), 32'd1);
    m1_req = 1'b0;
    for (int k = 20; k <= 40; k++) tick();
    check("t6.masked.m0_gnt", 32'(m0_gnt), 32'd0);
    check("t6.masked.m1_gnt", 32'(m1_gnt), 32'd0);
    m0_req = 1'b0;
    tick();
    m0_req = 1'b1;
    tick();
    check("t6.unmasked.m0_gnt", 32'(m0_gnt), 32'd1);
`else
    for (int k = 1; k <= 40; k++) begin
      tick();
      check($sformatf("t6.hold%0d.to", k), 32'(timeout), 32'd0);
    end
    check("t6.held.m0_gnt", 32'(m0_gnt), 32'd1);
    check("t6.held.m1_gnt", 32'(m1_gnt), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
